// File: rtl/id_stage_pipe.sv
// id_stage_pipe
// Decode stage for an RV32I subset sitting between fetch and EX.
// It decodes the presented instruction, reads the register file (with an
// optional write-through from WB), resolves branches and jumps so that fetch
// can be redirected in the accept cycle, stalls on load-use and
// branch/JALR operand hazards, and keeps an ID/EX output register that holds
// under back-pressure and can be flushed.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o   fetch-side handshake
//   instr_i, pc_i, pcPlus4_i  instruction word and its PCs
//   wb_we_i/addr/data         register file write port from WB
//   mem_regwrite_i, mem_rd_i  destination of the instruction in MEM
//   flush_i                   kill the output register, block acceptance
//   ex_ready_i / out_valid_o  EX-side handshake
//   RegWrite_o .. funct3_o    registered controls, operands and indices
//   redirect_o/_target_o      combinational fetch redirect
//   a0_o                      live contents of x10
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_WB = 1,
    parameter int BR_FULL   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pcPlus4_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            mem_regwrite_i,
    input  logic [4:0]      mem_rd_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    output logic            out_valid_o,
    output logic            RegWrite_o,
    output logic            ALUsrc_o,
    output logic            MemRead_o,
    output logic            MemWrite_o,
    output logic            illegal_o,
    output logic [1:0]      WriteSrc_o,
    output logic [1:0]      ALUOp_o,
    output logic [XLEN-1:0] ALUop1_o,
    output logic [XLEN-1:0] regOp2_o,
    output logic [XLEN-1:0] ImmOp_o,
    output logic [XLEN-1:0] pcPlus4_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_target_o,
    output logic [XLEN-1:0] a0_o
);

    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
        logic [1:0] write_src;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
    } id_ex_t;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    id_ex_t          out_q, out_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] funct3;
    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];

    logic               known, bad_f3, use_rs1, use_rs2, has_rd;
    logic               is_br, is_jal, is_jalr, illegal, br_taken;
    logic               load_use, br_dep1, br_dep2, hazard, accept;
    ctrl_t              dec_ctrl;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    imm, op1, op2, jalr_sum;

    function automatic logic idx_ok(input logic [4:0] idx);
        return int'(idx) < NREGS;
    endfunction

    // x0 and out-of-range indices read as zero; with BYPASS_WB the WB write
    // of this same cycle is visible to the read.
    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0 || !idx_ok(idx))
            return '0;
        if (BYPASS_WB != 0 && wb_we_i && wb_addr_i == idx)
            return wb_data_i;
        return regs_q[idx[AW-1:0]];
    endfunction

    // Register file next state: one write port from WB, x0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (wb_we_i && wb_addr_i != 5'd0 && idx_ok(wb_addr_i))
            regs_d[wb_addr_i[AW-1:0]] = wb_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Opcode decode. The use/has flags record which register fields the
    // format really carries, so garbage in unused fields never stalls or
    // marks the instruction illegal.
    always_comb begin
        known    = 1'b1;
        bad_f3   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        has_rd   = 1'b0;
        is_br    = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        dec_ctrl = '0;
        imm32    = '0;
        case (opcode)
            OP_R: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 2'b10;
            end
            OP_I: begin
                use_rs1 = 1'b1; has_rd = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = 2'b10;
                imm32 = 32'($signed(instr_i[31:20]));
            end
            OP_LOAD: begin
                use_rs1 = 1'b1; has_rd = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.write_src = 2'b01;
                dec_ctrl.mem_read  = 1'b1;
                imm32 = 32'($signed(instr_i[31:20]));
            end
            OP_STOR: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                imm32 = 32'($signed({instr_i[31:25], instr_i[11:7]}));
            end
            OP_BR: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_br = 1'b1;
                imm32 = 32'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                     instr_i[11:8], 1'b0}));
                // funct3 010/011 never exist; the magnitude compares exist
                // only in the full-branch build.
                bad_f3 = (funct3[2:1] == 2'b01) || (BR_FULL == 0 && funct3[2]);
            end
            OP_JAL: begin
                has_rd = 1'b1; is_jal = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.write_src = 2'b10;
                imm32 = 32'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                     instr_i[30:21], 1'b0}));
            end
            OP_JALR: begin
                use_rs1 = 1'b1; has_rd = 1'b1; is_jalr = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.write_src = 2'b10;
                imm32 = 32'($signed(instr_i[31:20]));
            end
            OP_LUI: begin
                has_rd = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.write_src = 2'b11;
                imm32 = $signed({instr_i[31:12], 12'b0});
            end
            default: known = 1'b0;
        endcase
        illegal = !known || bad_f3
                  || (use_rs1 && !idx_ok(rs1))
                  || (use_rs2 && !idx_ok(rs2))
                  || (has_rd  && !idx_ok(rd));
        if (illegal) begin
            dec_ctrl         = '0;
            dec_ctrl.illegal = 1'b1;
        end
    end

    // Immediate widening and operand fetch; unused sources read as zero.
    always_comb begin
        imm = XLEN'(imm32);
        op1 = use_rs1 ? read_reg(rs1) : '0;
        op2 = use_rs2 ? read_reg(rs2) : '0;
    end

    // Branch condition on the register operands.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (op1 == op2);
            3'b001:  br_taken = (op1 != op2);
            3'b100:  br_taken = ($signed(op1) <  $signed(op2));
            3'b101:  br_taken = ($signed(op1) >= $signed(op2));
            3'b110:  br_taken = (op1 <  op2);
            3'b111:  br_taken = (op1 >= op2);
            default: br_taken = 1'b0;
        endcase
    end

    // Hazards. Branches and JALR compare in ID, so any producer still in
    // ID/EX or MEM must finish first; other instructions only wait for a
    // load result that is not yet available.
    always_comb begin
        load_use = out_q.valid && out_q.ctrl.mem_read && out_q.rd != 5'd0
                   && ((use_rs1 && rs1 == out_q.rd) || (use_rs2 && rs2 == out_q.rd));
        br_dep1  = use_rs1 && rs1 != 5'd0
                   && ((out_q.valid && out_q.ctrl.reg_write && rs1 == out_q.rd)
                       || (mem_regwrite_i && rs1 == mem_rd_i));
        br_dep2  = use_rs2 && rs2 != 5'd0
                   && ((out_q.valid && out_q.ctrl.reg_write && rs2 == out_q.rd)
                       || (mem_regwrite_i && rs2 == mem_rd_i));
        hazard   = load_use || ((is_br || is_jalr) && (br_dep1 || br_dep2));
    end

    assign in_ready_o = !flush_i && !hazard && (!out_q.valid || ex_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        jalr_sum          = op1 + imm;
        redirect_o        = accept && !illegal && (is_jal || is_jalr || (is_br && br_taken));
        redirect_target_o = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_i + imm;
    end

    // ID/EX register: flush beats accept, accept beats drain. A flush or a
    // drain only clears the valid bit and controls; the data fields keep
    // their last contents.
    always_comb begin
        out_d = out_q;
        if (flush_i) begin
            out_d.valid = 1'b0;
            out_d.ctrl  = '0;
        end else if (accept) begin
            out_d.valid    = 1'b1;
            out_d.ctrl     = dec_ctrl;
            out_d.op1      = op1;
            out_d.op2      = op2;
            out_d.imm      = imm;
            out_d.pc_plus4 = pcPlus4_i;
            out_d.rs1      = rs1;
            out_d.rs2      = rs2;
            out_d.rd       = rd;
            out_d.funct3   = funct3;
        end else if (ex_ready_i) begin
            out_d.valid = 1'b0;
            out_d.ctrl  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            out_q <= '0;
        else
            out_q <= out_d;
    end

    assign out_valid_o = out_q.valid;
    assign RegWrite_o  = out_q.ctrl.reg_write;
    assign ALUsrc_o    = out_q.ctrl.alu_src;
    assign MemRead_o   = out_q.ctrl.mem_read;
    assign MemWrite_o  = out_q.ctrl.mem_write;
    assign illegal_o   = out_q.ctrl.illegal;
    assign WriteSrc_o  = out_q.ctrl.write_src;
    assign ALUOp_o     = out_q.ctrl.alu_op;
    assign ALUop1_o    = out_q.op1;
    assign regOp2_o    = out_q.op2;
    assign ImmOp_o     = out_q.imm;
    assign pcPlus4_o   = out_q.pc_plus4;
    assign rs1_o       = out_q.rs1;
    assign rs2_o       = out_q.rs2;
    assign rd_o        = out_q.rd;
    assign funct3_o    = out_q.funct3;
    assign a0_o        = regs_q[AW'(10)];

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe
// Self-checking bench for id_stage_pipe. The default build is driven by
// directed and random cycles and compared against a behavioural model of
// the stage; a second build (16 registers, no WB bypass, BEQ/BNE only)
// gets a few directed checks against constants.
module tb_id_stage_pipe;

    localparam int XLEN = 32;

    logic clk;
    logic rst, in_valid, wb_we, mem_rw, flush, ex_ready;
    logic [31:0] instr, pc, pc4, wb_data;
    logic [4:0]  wb_addr, mem_rd;
    logic        in_ready, out_valid, reg_write, alu_src, mem_read, mem_write, illegal;
    logic [1:0]  write_src, alu_op;
    logic [31:0] op1_o, op2_o, imm_o, pc4_o, target, a0;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [2:0]  f3_o;
    logic        redirect;

    logic b_rst, b_valid, b_we, b_mrw, b_flush, b_exr;
    logic [31:0] b_instr, b_pc, b_pc4, b_wdata;
    logic [4:0]  b_waddr, b_mrd;
    logic        b_ready, b_out_valid, b_rw, b_as, b_mr, b_mw, b_ill, b_redir;
    logic [1:0]  b_ws, b_ao;
    logic [31:0] b_op1, b_op2, b_imm, b_pc4o, b_tgt, b_a0;
    logic [4:0]  b_rs1o, b_rs2o, b_rdo;
    logic [2:0]  b_f3o;

    id_stage_pipe dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .pc_i(pc), .pcPlus4_i(pc4),
        .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .mem_regwrite_i(mem_rw), .mem_rd_i(mem_rd), .flush_i(flush),
        .ex_ready_i(ex_ready), .out_valid_o(out_valid),
        .RegWrite_o(reg_write), .ALUsrc_o(alu_src), .MemRead_o(mem_read),
        .MemWrite_o(mem_write), .illegal_o(illegal), .WriteSrc_o(write_src),
        .ALUOp_o(alu_op), .ALUop1_o(op1_o), .regOp2_o(op2_o), .ImmOp_o(imm_o),
        .pcPlus4_o(pc4_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .funct3_o(f3_o), .redirect_o(redirect), .redirect_target_o(target),
        .a0_o(a0)
    );

    id_stage_pipe #(.XLEN(32), .NREGS(16), .BYPASS_WB(0), .BR_FULL(0)) dut16 (
        .clk_i(clk), .rst_i(b_rst), .in_valid_i(b_valid), .in_ready_o(b_ready),
        .instr_i(b_instr), .pc_i(b_pc), .pcPlus4_i(b_pc4),
        .wb_we_i(b_we), .wb_addr_i(b_waddr), .wb_data_i(b_wdata),
        .mem_regwrite_i(b_mrw), .mem_rd_i(b_mrd), .flush_i(b_flush),
        .ex_ready_i(b_exr), .out_valid_o(b_out_valid),
        .RegWrite_o(b_rw), .ALUsrc_o(b_as), .MemRead_o(b_mr),
        .MemWrite_o(b_mw), .illegal_o(b_ill), .WriteSrc_o(b_ws),
        .ALUOp_o(b_ao), .ALUop1_o(b_op1), .regOp2_o(b_op2), .ImmOp_o(b_imm),
        .pcPlus4_o(b_pc4o), .rs1_o(b_rs1o), .rs2_o(b_rs2o), .rd_o(b_rdo),
        .funct3_o(b_f3o), .redirect_o(b_redir), .redirect_target_o(b_tgt),
        .a0_o(b_a0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctrl packing: {RegWrite, ALUsrc, MemRead, MemWrite, illegal, WriteSrc, ALUOp}
    typedef struct packed {
        logic        valid;
        logic [8:0]  ctrl;
        logic [31:0] op1, op2, imm, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
    } oreg_t;

    typedef struct packed {
        logic        ill, use1, use2, br, jal, jalr;
        logic [8:0]  ctrl;
        logic [31:0] imm;
    } dec_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_regs [32];
    oreg_t       m_out;
    logic        obs_ready, obs_redirect, b_obs_ready, b_obs_redirect;
    logic [31:0] obs_target;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Decode rules of the instruction subset, straight from the opcode table.
    function automatic dec_t mdecode(input logic [31:0] w);
        dec_t d;
        logic rw, as, mr, mw, known;
        logic [1:0] ws, ao;
        d = '0; rw = 0; as = 0; mr = 0; mw = 0; ws = 0; ao = 0; known = 1;
        case (w[6:0])
            7'b0110011: begin rw = 1; ao = 2; d.use1 = 1; d.use2 = 1; end
            7'b0010011: begin rw = 1; as = 1; ao = 2; d.use1 = 1;
                              d.imm = {{20{w[31]}}, w[31:20]}; end
            7'b0000011: begin rw = 1; as = 1; ws = 1; mr = 1; d.use1 = 1;
                              d.imm = {{20{w[31]}}, w[31:20]}; end
            7'b0100011: begin as = 1; mw = 1; d.use1 = 1; d.use2 = 1;
                              d.imm = {{20{w[31]}}, w[31:25], w[11:7]}; end
            7'b1100011: begin d.br = 1; d.use1 = 1; d.use2 = 1;
                              d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                              if (w[14:12] == 3'd2 || w[14:12] == 3'd3) known = 0; end
            7'b1101111: begin rw = 1; ws = 2; d.jal = 1;
                              d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
            7'b1100111: begin rw = 1; ws = 2; d.jalr = 1; d.use1 = 1;
                              d.imm = {{20{w[31]}}, w[31:20]}; end
            7'b0110111: begin rw = 1; as = 1; ws = 3; d.imm = {w[31:12], 12'b0}; end
            default:    known = 0;
        endcase
        d.ill  = !known;
        d.ctrl = d.ill ? 9'b0000_1_00_00 : {rw, as, mr, mw, 1'b0, ws, ao};
        return d;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (wb_we && wb_addr == idx) return wb_data;
        return m_regs[idx];
    endfunction

    // One cycle on the default build: drive at the falling edge, check the
    // combinational outputs, step the model, check the registered outputs.
    task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] p,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic mrw, input logic [4:0] mrd, input logic fl,
                                 input logic exr, input logic rs);
        dec_t d;
        logic [31:0] a, b, tgt;
        logic haz, rdy, acc, taken, redir;
        logic [4:0] s1, s2;
        @(negedge clk);
        in_valid = v; instr = w; pc = p; pc4 = p + 32'd4;
        wb_we = we; wb_addr = wa; wb_data = wd;
        mem_rw = mrw; mem_rd = mrd; flush = fl; ex_ready = exr; rst = rs;
        #1;
        d  = mdecode(w);
        s1 = w[19:15]; s2 = w[24:20];
        a  = d.use1 ? mread(s1) : 32'd0;
        b  = d.use2 ? mread(s2) : 32'd0;
        haz = m_out.valid && m_out.ctrl[6] && m_out.rd != 0
              && ((d.use1 && s1 == m_out.rd) || (d.use2 && s2 == m_out.rd));
        if (d.br || d.jalr) begin
            if (d.use1 && s1 != 0 && ((m_out.valid && m_out.ctrl[8] && s1 == m_out.rd)
                                      || (mrw && s1 == mrd))) haz = 1;
            if (d.use2 && s2 != 0 && ((m_out.valid && m_out.ctrl[8] && s2 == m_out.rd)
                                      || (mrw && s2 == mrd))) haz = 1;
        end
        rdy = !fl && !haz && (!m_out.valid || exr);
        acc = v && rdy;
        case (w[14:12])
            3'd0: taken = (a == b);
            3'd1: taken = (a != b);
            3'd4: taken = ($signed(a) <  $signed(b));
            3'd5: taken = ($signed(a) >= $signed(b));
            3'd6: taken = (a <  b);
            3'd7: taken = (a >= b);
            default: taken = 0;
        endcase
        redir = acc && !d.ill && (d.jal || d.jalr || (d.br && taken));
        tgt   = d.jalr ? ((a + d.imm) & 32'hFFFF_FFFE) : (p + d.imm);
        obs_ready = in_ready; obs_redirect = redirect; obs_target = target;
        checkOutput("in_ready", 64'(in_ready), 64'(rdy));
        checkOutput("redirect", 64'(redirect), 64'(redir));
        if (redir) checkOutput("target", 64'(target), 64'(tgt));
        if (rs) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_out = '0;
        end else begin
            if (we && wa != 0) m_regs[wa] = wd;
            if (fl) begin
                m_out.valid = 0; m_out.ctrl = '0;
            end else if (acc) begin
                m_out = {1'b1, d.ctrl, a, b, d.imm, p + 32'd4, s1, s2, w[11:7], w[14:12]};
            end else if (exr) begin
                m_out.valid = 0; m_out.ctrl = '0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid", 64'(out_valid), 64'(m_out.valid));
        checkOutput("ctrl", 64'({reg_write, alu_src, mem_read, mem_write, illegal, write_src, alu_op}),
                    64'(m_out.ctrl));
        checkOutput("ALUop1", 64'(op1_o), 64'(m_out.op1));
        checkOutput("regOp2", 64'(op2_o), 64'(m_out.op2));
        checkOutput("ImmOp", 64'(imm_o), 64'(m_out.imm));
        checkOutput("pcPlus4", 64'(pc4_o), 64'(m_out.pc4));
        checkOutput("indices", 64'({rs1_o, rs2_o, rd_o, f3_o}),
                    64'({m_out.rs1, m_out.rs2, m_out.rd, m_out.f3}));
        checkOutput("a0", 64'(a0), 64'(m_regs[10]));
    endtask

    // One cycle on the reduced build; results are checked by the caller.
    task automatic stepB(input logic v, input logic [31:0] w, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic rs);
        @(negedge clk);
        b_valid = v; b_instr = w; b_we = we; b_waddr = wa; b_wdata = wd;
        b_exr = 1'b1; b_rst = rs;
        #1;
        b_obs_ready = b_ready; b_obs_redirect = b_redir;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rand_reg();
        int k;
        k = $urandom_range(0, 7);
        return (k == 7) ? 5'd10 : 5'(k);
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k != 9) begin
            w[11:7] = rand_reg(); w[19:15] = rand_reg(); w[24:20] = rand_reg();
            case (k)
                0: w[6:0] = 7'b0110011;
                1: w[6:0] = 7'b0010011;
                2: w[6:0] = 7'b0000011;
                3: w[6:0] = 7'b0100011;
                4: w[6:0] = 7'b1100011;
                5: w[6:0] = 7'b1101111;
                6: w[6:0] = 7'b1100111;
                7: w[6:0] = 7'b0110111;
                default: w[6:0] = 7'b0010111;
            endcase
        end
        return w;
    endfunction

    localparam logic [31:0] ADDI_A0 = 32'h0050_0513;
    localparam logic [31:0] LW_X5   = 32'h0000_A283;
    localparam logic [31:0] ADD_X6  = 32'h0052_8333;
    localparam logic [31:0] BEQ_16  = 32'h0020_8863;
    localparam logic [31:0] JALR_X1 = 32'h0032_00E7;
    localparam logic [31:0] ADD_X7  = 32'h0001_83B3;
    localparam logic [31:0] ADD_X20 = 32'h0020_8A33;
    localparam logic [31:0] BGE_16  = 32'h0020_D863;

    initial begin
        rst = 1; in_valid = 0; instr = 0; pc = 0; pc4 = 0; wb_we = 0; wb_addr = 0;
        wb_data = 0; mem_rw = 0; mem_rd = 0; flush = 0; ex_ready = 0;
        b_rst = 1; b_valid = 0; b_instr = 0; b_pc = 32'h40; b_pc4 = 32'h44; b_we = 0;
        b_waddr = 0; b_wdata = 0; b_mrw = 0; b_mrd = 0; b_flush = 0; b_exr = 1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_out = '0;

        // Reduced build: index range, no bypass, BEQ/BNE only.
        stepB(0, 0, 0, 0, 0, 1);
        checkOutput("b_rst_valid", 64'(b_out_valid), 64'd0);
        stepB(1, ADD_X20, 0, 0, 0, 0);
        checkOutput("b_x20_illegal", 64'(b_ill), 64'd1);
        checkOutput("b_x20_ctrl", 64'({b_rw, b_as, b_mr, b_mw, b_ws, b_ao}), 64'd0);
        checkOutput("b_x20_valid", 64'(b_out_valid), 64'd1);
        stepB(1, ADD_X7, 1, 5'd3, 32'h55, 0);
        checkOutput("b_nobypass_old", 64'(b_op1), 64'd0);
        stepB(1, ADD_X7, 0, 0, 0, 0);
        checkOutput("b_nobypass_new", 64'(b_op1), 64'h55);
        stepB(1, BGE_16, 0, 0, 0, 0);
        checkOutput("b_bge_ready", 64'(b_obs_ready), 64'd1);
        checkOutput("b_bge_redirect", 64'(b_obs_redirect), 64'd0);
        checkOutput("b_bge_illegal", 64'(b_ill), 64'd1);

        // Default build, directed.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_a0", 64'(a0), 64'd0);
        applyStimulus(1, ADDI_A0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("addi_valid", 64'(out_valid), 64'd1);
        checkOutput("addi_imm", 64'(imm_o), 64'd5);
        checkOutput("addi_alusrc", 64'(alu_src), 64'd1);
        applyStimulus(0, 0, 0, 1, 5'd10, 32'd5, 0, 0, 0, 1, 0);
        checkOutput("a0_after_wb", 64'(a0), 64'd5);

        applyStimulus(1, LW_X5, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, ADD_X6, 32'h14, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("loaduse_stall", 64'(obs_ready), 64'd0);
        checkOutput("loaduse_bubble", 64'(out_valid), 64'd0);
        applyStimulus(1, ADD_X6, 32'h14, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("loaduse_accept", 64'(obs_ready), 64'd1);

        applyStimulus(0, 0, 0, 1, 5'd1, 32'd7, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 5'd2, 32'd7, 0, 0, 0, 1, 0);
        applyStimulus(1, BEQ_16, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("beq_taken", 64'(obs_redirect), 64'd1);
        checkOutput("beq_target", 64'(obs_target), 64'h110);
        applyStimulus(0, 0, 0, 1, 5'd2, 32'd8, 0, 0, 0, 1, 0);
        applyStimulus(1, BEQ_16, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("beq_not_taken", 64'(obs_redirect), 64'd0);

        applyStimulus(0, 0, 0, 1, 5'd4, 32'h200, 0, 0, 0, 1, 0);
        applyStimulus(1, JALR_X1, 32'h180, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("jalr_redirect", 64'(obs_redirect), 64'd1);
        checkOutput("jalr_target", 64'(obs_target), 64'h202);
        checkOutput("jalr_writesrc", 64'(write_src), 64'd2);
        checkOutput("jalr_regwrite", 64'(reg_write), 64'd1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, ADDI_A0, 32'h184, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("hold_ready", 64'(obs_ready), 64'd0);
            checkOutput("hold_writesrc", 64'(write_src), 64'd2);
        end
        applyStimulus(1, ADDI_A0, 32'h184, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("flush_ready", 64'(obs_ready), 64'd0);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);

        applyStimulus(1, ADD_X7, 32'h200, 1, 5'd3, 32'h66, 0, 0, 0, 1, 0);
        checkOutput("bypass_op1", 64'(op1_o), 64'h66);

        applyStimulus(1, LW_X5, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, ADD_X6, 32'h14, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("rststall_ready", 64'(obs_ready), 64'd0);
        checkOutput("rststall_valid", 64'(out_valid), 64'd0);
        applyStimulus(1, ADD_X6, 32'h14, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rststall_after", 64'(obs_ready), 64'd1);

        // Default build, random.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
                          1'($urandom_range(0, 1)), rand_reg(), rand_data(),
                          $urandom_range(0, 3) == 0, rand_reg(),
                          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                          i == 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage with a valid/ready handshake on both sides.
- Decodes an RV32I subset, reads a parametrised register file with write-through from WB, and resolves branches and jumps in ID.
- Detects load-use and ID-operand hazards and inserts bubbles.
- Holds its ID/EX output register under back-pressure, with flush support.
- Sits between the fetch stage (upstream) and the EX stage (downstream).

Parameters:
- XLEN, 32: datapath width of PC, registers and immediates (32 or 64).
- NREGS, 32: architectural register count (16 or 32); index bits above $clog2(NREGS) must be zero.
- BYPASS_WB, 1: 1 = a register read returns WB data written in the same cycle; 0 = the read returns the old value.
- BR_FULL, 1: 1 = BLT/BGE/BLTU/BGEU supported; 0 = only BEQ/BNE, and other branch funct3 values are illegal.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  fetch presents an instruction
- in_ready_o  out  1  stage accepts the instruction this cycle
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction PC
- pcPlus4_i  in  XLEN  PC+4
- wb_we_i  in  1  WB register write enable
- wb_addr_i  in  5  WB destination register
- wb_data_i  in  XLEN  WB write data
- mem_regwrite_i  in  1  instruction in MEM writes a register
- mem_rd_i  in  5  destination of the instruction in MEM
- flush_i  in  1  kill the output register contents and block acceptance
- ex_ready_i  in  1  EX consumes out_valid_o this cycle
- out_valid_o  out  1  output register holds a valid instruction
- RegWrite_o, ALUsrc_o, MemRead_o, MemWrite_o, illegal_o  out  1 each  registered controls
- WriteSrc_o  out  2  registered: 00 ALU, 01 memory, 10 pc+4, 11 immediate
- ALUOp_o  out  2  registered: 00 add, 01 subtract, 10 funct-decoded
- ALUop1_o, regOp2_o, ImmOp_o, pcPlus4_o  out  XLEN each  registered operands
- rs1_o, rs2_o, rd_o  out  5 each  registered register indices
- funct3_o  out  3  registered funct3
- redirect_o  out  1  taken branch or jump accepted this cycle (combinational)
- redirect_target_o  out  XLEN  redirect address (combinational)
- a0_o  out  XLEN  live value of x10

Behaviour:
- Decode by opcode; fields not listed are 0:
  - 0110011: RegWrite, ALUOp=10.
  - 0010011: RegWrite, ALUsrc, ALUOp=10, I-immediate.
  - 0000011: RegWrite, ALUsrc, WriteSrc=01, MemRead, I-immediate.
  - 0100011: ALUsrc, MemWrite, S-immediate.
  - 1100011: branch, B-immediate.
  - 1101111: RegWrite, WriteSrc=10, J-immediate.
  - 1100111: RegWrite, WriteSrc=10, I-immediate.
  - 0110111: RegWrite, ALUsrc, WriteSrc=11, U-immediate.
- Any other opcode, a register index ≥ NREGS, or an unsupported branch funct3 sets illegal and forces all controls to 0.
- Immediates are sign-extended to XLEN.
- Register file: NREGS x XLEN.
  - Writes on the rising edge when wb_we_i=1 and wb_addr_i≠0.
  - x0 always reads 0.
  - Reads are combinational; BYPASS_WB selects write-through.
  - rst_i clears all registers to 0.
- Operand reads use rs1/rs2 only where the format has them; unused source fields never cause a stall.
- Hazard (in_ready_o=0) is raised when any of:
  - out_valid_o, MemRead_o, rd_o≠0, and rd_o equals a used source register (load-use);
  - the instruction is a branch or JALR, a used source register ≠0 matches rd_o (with out_valid_o and RegWrite_o), or matches mem_rd_i (with mem_regwrite_i).
- in_ready_o = !flush_i && !hazard && (!out_valid_o || ex_ready_i).
- Accept = in_valid_i && in_ready_o. Output register update priority:
  1. rst_i or flush_i: out_valid_o←0, all registered controls←0.
  2. Accept: load the new instruction, out_valid_o←1.
  3. ex_ready_i: out_valid_o←0 and controls←0 (bubble).
  4. Otherwise: hold all outputs.
- While the output register holds, its data outputs are stable.
- Redirect:
  - redirect_o = accept && !illegal && (JAL || JALR || branch condition true).
  - Branch conditions: EQ, NE, signed LT/GE, unsigned LTU/GEU on the register values.
  - Target: JAL/branch = pc_i+imm; JALR = (rs1+imm) with bit 0 cleared. Arithmetic is modulo 2^XLEN.
  - redirect_o=0 when not accepting, including under hazard or flush.
- Flush and accept in the same cycle cannot happen, because in_ready_o=0 during flush.
- Reset mid-stall: the next cycle has out_valid_o=0 and in_ready_o=1 (when flush_i=0).
- Reset values: all registered outputs are 0; a0_o=0.

Test Plan:
- Reset, then addi x10,x0,5 (0x00500513) with ex_ready_i=1 → next cycle out_valid_o=1, ImmOp_o=5, ALUsrc_o=1; after WB writes x10=5, a0_o=5.
- lw x5,0(x1) accepted, then add x6,x5,x5 presented → in_ready_o=0 for 1 cycle, bubble out_valid_o=0, accepted the following cycle.
- x1=x2=7 (written via WB), beq x1,x2,+16 at pc 0x100 → redirect_o=1 in the accept cycle, redirect_target_o=0x110; with x2=8 → redirect_o=0.
- jalr x1,3(x4) with x4=0x200 → redirect_target_o=0x202 (bit 0 cleared), WriteSrc_o=10, RegWrite_o=1.
- ex_ready_i=0 for 3 cycles with a valid output → outputs held stable, in_ready_o=0; flush_i=1 → out_valid_o=0 next cycle.
- NREGS=16: add x20,x1,x2 → illegal_o=1, all controls 0; WB write to x3 and read of x3 in the same cycle returns the new data with BYPASS_WB=1 and the old data with 0.
